// File: rtl/dm_responder_if.sv
// dm_responder_if: M-stage load/store request bus between the pipeline (master) and the data memory (slave).
interface dm_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        ack;
  logic [31:0] rd;
  logic        busy;
  logic        err;
  modport master (output req, we, addr, be, wd, input ack, rd, busy, err);
  modport slave  (input req, we, addr, be, wd, output ack, rd, busy, err);
endinterface

// File: rtl/dm_responder.sv
// dm_responder: word RAM with byte enables, LATENCY wait states and a one-cycle Ack carrying read data.
// Optional macro DM_ALIGN_CHECK_EN rejects misaligned byte-enable patterns with Err.
module dm_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input logic           clk,
  input logic           rst_n,
  dm_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      be_q;
  logic [31:0]     wd_q;
  logic            ack_q;
  logic            busy_q;
  logic            err_q;
  logic [31:0]     rd_q;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            idle;
  logic            go_resp;
  logic            c_we;
  logic            illegal;
  logic [AW-1:0]   c_idx;
  logic [3:0]      c_be;
  logic [31:0]     c_wd;
  logic [31:0]     merged;
  logic            unused_addr;
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  // With zero wait states the access completes on the accept edge, so it must use the live inputs.
  always_comb begin
    idle    = state_q == IDLE;
    go_resp = (idle && bus.req && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1);
    c_we    = idle ? bus.we : we_q;
    c_idx   = idle ? bus.addr[AW+1:2] : idx_q;
    c_be    = idle ? bus.be : be_q;
    c_wd    = idle ? bus.wd : wd_q;
    merged  = mem[c_idx];
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = (c_we && c_be[i]) ? c_wd[8*i +: 8] : mem[c_idx][8*i +: 8];
`ifdef DM_ALIGN_CHECK_EN
    illegal = !(c_be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
              && !(c_be == 4'b0000 && !c_we);
`else
    illegal = 1'b0;
`endif
  end
  always_ff @(posedge clk)
    if (rst_n && go_resp && c_we && !illegal) mem[c_idx] <= merged;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      ack_q <= go_resp;
      err_q <= go_resp && illegal;
      rd_q  <= (go_resp && !illegal) ? merged : '0;
      case (state_q)
        IDLE: if (bus.req) begin
          we_q    <= bus.we;
          idx_q   <= bus.addr[AW+1:2];
          be_q    <= bus.be;
          wd_q    <= bus.wd;
          cnt_q   <= 4'(LATENCY);
          busy_q  <= 1'b1;
          state_q <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? RESP : WAIT;
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.ack  = ack_q;
  assign bus.rd   = rd_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: random and directed accesses on a LATENCY=2 and a LATENCY=0 responder against a word-map model.
module tb_dm_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dm_responder_if b2 ();
  dm_responder_if b0 ();
  dm_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  dm_responder #(.DEPTH_WORDS(4096), .LATENCY(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] mm [int];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  function automatic logic legal(input logic we, input logic [3:0] be);
`ifdef DM_ALIGN_CHECK_EN
    return be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF} || (be == 4'h0 && !we);
`else
    return 1'b1;
`endif
  endfunction
  function automatic logic [31:0] mask_of(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
  function automatic logic [31:0] rnd_addr(input int idx);
    return ($urandom & 32'hFFFF_C003) | (32'(idx) << 2);
  endfunction
  task automatic scramble2();
    b2.we = 1'($urandom); b2.addr = $urandom; b2.be = 4'($urandom); b2.wd = $urandom;
  endtask
  // One access on the LATENCY=2 responder; the model decides RD/Err and updates the word map.
  task automatic acc(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input string tag);
    int idx;
    int lat;
    int nb;
    logic [31:0] old;
    logic [31:0] exp_rd;
    logic [31:0] rd_got;
    logic ok;
    logic err_got;
    idx = int'(addr[13:2]);
    old = mm.exists(idx) ? mm[idx] : 32'h0;
    ok = legal(we, be);
    exp_rd = !ok ? 32'h0 : we ? ((old & ~mask_of(be)) | (wd & mask_of(be))) : old;
    if (ok && we) mm[idx] = exp_rd;
    lat = 0; nb = 0; rd_got = 0; err_got = 0;
    @(negedge clk);
    b2.req = 1'b1; b2.we = we; b2.addr = addr; b2.be = be; b2.wd = wd;
    @(posedge clk); #1;
    b2.req = 1'b0;
    scramble2();
    for (int k = 1; k <= 20; k++) begin
      if (b2.busy) nb++;
      if (b2.ack) begin
        lat = k; rd_got = b2.rd; err_got = b2.err;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " ack latency"}, 32'(lat), 32'd3);
    chk({tag, " busy cycles"}, 32'(nb), 32'd3);
    chk({tag, " rd"}, rd_got, exp_rd);
    chk({tag, " err"}, 32'(err_got), 32'(!ok));
    @(posedge clk); #1;
    chk({tag, " ack after"}, 32'(b2.ack), 32'd0);
    chk({tag, " busy after"}, 32'(b2.busy), 32'd0);
    chk({tag, " rd after"}, b2.rd, 32'h0);
  endtask
  initial begin
    int nack;
    logic [31:0] cur;
    b2.req = 0; b2.we = 0; b2.addr = 0; b2.be = 0; b2.wd = 0;
    b0.req = 0; b0.we = 0; b0.addr = 0; b0.be = 0; b0.wd = 0;
    #22;
    chk("reset ack", 32'(b2.ack), 32'd0);
    chk("reset busy", 32'(b2.busy), 32'd0);
    chk("reset err", 32'(b2.err), 32'd0);
    chk("reset rd", b2.rd, 32'h0);
    chk("reset ack0", 32'(b0.ack), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    acc(1'b1, 32'h0, 4'hF, 32'h1234_5678, "t1 preset");
    acc(1'b0, 32'h0, 4'h0, 32'h0, "t1 load");
    acc(1'b1, 32'h10, 4'hF, 32'h0, "t2 clear");
    acc(1'b1, 32'h10, 4'b0100, 32'hAABB_CCDD, "t2 store");
    acc(1'b0, 32'h10, 4'hF, 32'h0, "t2 load");
    chk("t2 model", mm[4], 32'h00BB_0000);
    acc(1'b1, 32'h4000, 4'hF, 32'hCAFE_F00D, "t4 store");
    acc(1'b0, 32'h0, 4'hF, 32'h0, "t4 wrap load");
    acc(1'b1, 32'h20, 4'hF, 32'h1122_3344, "t6 preset");
    acc(1'b1, 32'h20, 4'b0110, 32'h5566_7788, "t6 store");
    acc(1'b0, 32'h20, 4'hF, 32'h0, "t6 load");
    acc(1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF, "be0 store");
    // Reset while the store is still waiting: no write, no Ack.
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h20; b2.be = 4'hF; b2.wd = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    b2.req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t5 ack in reset", 32'(b2.ack), 32'd0);
    chk("t5 busy in reset", 32'(b2.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (b2.ack) nack++;
    end
    chk("t5 no ack", 32'(nack), 32'd0);
    acc(1'b0, 32'h20, 4'hF, 32'h0, "t5 load");
    // Reset during the Ack cycle: Ack drops at once, the write stays.
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h14; b2.be = 4'hF; b2.wd = 32'h0BAD_F00D;
    mm[5] = 32'h0BAD_F00D;
    @(posedge clk); #1;
    b2.req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("resp ack", 32'(b2.ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("resp reset ack", 32'(b2.ack), 32'd0);
    chk("resp reset rd", b2.rd, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    acc(1'b0, 32'h14, 4'hF, 32'h0, "resp load");
    // Req held high on the zero-latency responder: an accept every second cycle.
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b1; b0.be = 4'hF; b0.addr = $urandom; b0.wd = $urandom;
    nack = 0;
    for (int k = 0; k < 12; k++) begin
      cur = b0.wd;
      @(posedge clk); #1;
      chk($sformatf("t3 ack cyc%0d", k), 32'(b0.ack), 32'(k % 2 == 0));
      if (b0.ack) nack++;
      if (k % 2 == 0) chk($sformatf("t3 rd cyc%0d", k), b0.rd, cur);
      b0.addr = $urandom; b0.wd = $urandom;
    end
    @(negedge clk); b0.req = 1'b0;
    chk("t3 ack count", 32'(nack), 32'd6);
    for (int i = 0; i < 16; i++) acc(1'b1, rnd_addr(i), 4'hF, $urandom, "init");
    for (int i = 0; i < 60; i++)
      acc(1'($urandom), rnd_addr(int'($urandom_range(0, 15))), 4'($urandom), $urandom, "rnd");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
